// File: rtl/cv32e40s_pkg.sv
// Shared decode constants and data types for the X-interface ALU coprocessor.
package cv32e40s_pkg;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
  localparam logic [2:0] FUNCT3_ADD     = 3'b000;
  localparam logic [2:0] FUNCT3_XOR     = 3'b001;
  localparam logic [2:0] FUNCT3_MIN     = 3'b010;

  typedef enum logic [1:0] {OP_ADD, OP_XOR, OP_MIN, OP_NONE} alu_op_e;

  typedef struct packed {
    logic        valid;
    logic        committed;
    logic        killed;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic ecswrite;
    logic exc;
  } issue_resp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        accept;
  } compressed_resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_result_t;

  function automatic alu_op_e decode_op(input logic [31:0] instr);
    decode_op = OP_NONE;
    if (instr[6:0] == OPCODE_CUSTOM0 && instr[31:25] == 7'b0) begin
      case (instr[14:12])
        FUNCT3_ADD: decode_op = OP_ADD;
        FUNCT3_XOR: decode_op = OP_XOR;
        FUNCT3_MIN: decode_op = OP_MIN;
        default:    decode_op = OP_NONE;
      endcase
    end
  endfunction

endpackage

// File: rtl/cv32e40s_xif_coproc_if.sv
// Core <-> coprocessor eXtension interface, with one modport per channel on the coprocessor side.
interface if_xif #(
  parameter int X_ID_WIDTH = 4,
  parameter int X_NUM_RS   = 2
) ();
  import cv32e40s_pkg::*;

  logic                         compressed_valid;
  logic                         compressed_ready;
  logic [15:0]                  compressed_instr;
  compressed_resp_t             compressed_resp;

  logic                         issue_valid;
  logic                         issue_ready;
  logic [31:0]                  issue_instr;
  logic [X_ID_WIDTH-1:0]        issue_id;
  logic [X_NUM_RS-1:0][31:0]    issue_rs;
  logic [X_NUM_RS-1:0]          issue_rs_valid;
  issue_resp_t                  issue_resp;

  logic                         commit_valid;
  logic [X_ID_WIDTH-1:0]        commit_id;
  logic                         commit_kill;

  logic                         mem_valid;
  logic                         mem_ready;
  mem_req_t                     mem_req;
  logic                         mem_result_valid;
  mem_result_t                  mem_result;

  logic                         result_valid;
  logic                         result_ready;
  logic [X_ID_WIDTH-1:0]        result_id;
  logic [31:0]                  result_data;
  logic [4:0]                   result_rd;
  logic                         result_we;
  logic [5:0]                   result_ecsdata;
  logic [2:0]                   result_ecswe;
  logic                         result_exc;
  logic [5:0]                   result_exccode;
  logic                         result_err;
  logic                         result_dbg;

  modport coproc_compressed (input compressed_valid, compressed_instr,
                             output compressed_ready, compressed_resp);
  modport coproc_issue      (input issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
                             output issue_ready, issue_resp);
  modport coproc_commit     (input commit_valid, commit_id, commit_kill);
  modport coproc_mem        (input mem_ready, output mem_valid, mem_req);
  modport coproc_mem_result (input mem_result_valid, mem_result);
  modport coproc_result     (input result_ready,
                             output result_valid, result_id, result_data, result_rd, result_we,
                                    result_ecsdata, result_ecswe, result_exc, result_exccode,
                                    result_err, result_dbg);

endinterface

// File: rtl/cv32e40s_xif_coproc_buf.sv
// In-order in-flight instruction buffer: allocation, commit/kill by ID search, head pop.
module cv32e40s_xif_coproc_buf
  import cv32e40s_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [ID_WIDTH-1:0] push_id,
  input  logic [4:0]          push_rd,
  input  logic [31:0]         push_data,
  input  logic                commit_valid,
  input  logic [ID_WIDTH-1:0] commit_id,
  input  logic                commit_kill,
  input  logic                result_ready,
  output logic                full,
  output logic                head_valid,
  output logic [ID_WIDTH-1:0] head_id,
  output logic [4:0]          head_rd,
  output logic [31:0]         head_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]      wptr_q, rptr_q;
  entry_t              entries_q [DEPTH];
  logic [ID_WIDTH-1:0] ids_q     [DEPTH];

  logic [PTR_W-1:0] widx, ridx;
  entry_t           head;
  logic             pop, new_hit;

  assign widx = wptr_q[PTR_W-1:0];
  assign ridx = rptr_q[PTR_W-1:0];
  assign head = entries_q[ridx];

  // Extra MSB separates full (MSBs differ) from empty (MSBs equal) when indices match.
  assign full = (wptr_q[PTR_W] != rptr_q[PTR_W]) && (widx == ridx);

  // A killed head leaves silently; a live one needs the core to take it.
  assign pop     = head.valid && (head.killed || (head.committed && result_ready));
  assign new_hit = commit_valid && push && (commit_id == push_id);

  assign head_valid = head.valid && head.committed && !head.killed;
  assign head_id    = ids_q[ridx];
  assign head_rd    = head.rd;
  assign head_data  = head.data;

  // NOTE: sequential state is written with non-blocking assignments so every
  // read in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      // NOTE: the whole array is reset, not just the flags; it is only DEPTH
      // entries and it keeps ID/payload free of X after a mid-operation reset.
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
        ids_q[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_valid && entries_q[i].valid && ids_q[i] == commit_id) begin
          if (commit_kill) entries_q[i].killed    <= 1'b1;
          else             entries_q[i].committed <= 1'b1;
        end
      end
      if (pop) begin
        entries_q[ridx].valid <= 1'b0;
        rptr_q                <= rptr_q + 1'b1;
      end
      if (push) begin
        entries_q[widx] <= '{valid:     1'b1,
                             committed: new_hit && !commit_kill,
                             killed:    new_hit && commit_kill,
                             rd:        push_rd,
                             data:      push_data};
        ids_q[widx]     <= push_id;
        wptr_q          <= wptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cv32e40s_xif_coproc.sv
// X-interface coprocessor executing custom-0 ADD/XOR/MIN; results return in order after commit.
module cv32e40s_xif_coproc
  import cv32e40s_pkg::*;
#(
  parameter int X_ID_WIDTH = 4,
  parameter int X_NUM_RS   = 2,
  parameter int DEPTH      = 4
) (
  input logic                  clk,
  input logic                  rst,
  if_xif.coproc_compressed     xif_compressed,
  if_xif.coproc_issue          xif_issue,
  if_xif.coproc_commit         xif_commit,
  if_xif.coproc_mem            xif_mem,
  if_xif.coproc_mem_result     xif_mem_result,
  if_xif.coproc_result         xif_result
);

  logic [31:0] instr, rs0, rs1, alu_result;
  alu_op_e     op;
  logic        recognized, full, push;

  assign instr      = xif_issue.issue_instr;
  assign rs0        = xif_issue.issue_rs[0];
  assign rs1        = xif_issue.issue_rs[1];
  assign op         = decode_op(instr);
  assign recognized = (op != OP_NONE);

  // NOTE: default assigned first so no path through the case can infer a latch.
  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:  alu_result = rs0 + rs1;
      OP_XOR:  alu_result = rs0 ^ rs1;
      OP_MIN:  alu_result = ($signed(rs0) < $signed(rs1)) ? rs0 : rs1;
      default: alu_result = '0;
    endcase
  end

  // Rejected instructions are never held back, so the core can move on at once.
  assign xif_issue.issue_ready = recognized ? ((&xif_issue.issue_rs_valid[1:0]) && !full) : 1'b1;

  always_comb begin
    xif_issue.issue_resp           = '0;
    xif_issue.issue_resp.accept    = recognized;
    xif_issue.issue_resp.writeback = recognized;
  end

  assign push = xif_issue.issue_valid && xif_issue.issue_ready && recognized;

  cv32e40s_xif_coproc_buf #(
    .DEPTH    (DEPTH),
    .ID_WIDTH (X_ID_WIDTH)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_id      (xif_issue.issue_id),
    .push_rd      (instr[11:7]),
    .push_data    (alu_result),
    .commit_valid (xif_commit.commit_valid),
    .commit_id    (xif_commit.commit_id),
    .commit_kill  (xif_commit.commit_kill),
    .result_ready (xif_result.result_ready),
    .full         (full),
    .head_valid   (xif_result.result_valid),
    .head_id      (xif_result.result_id),
    .head_rd      (xif_result.result_rd),
    .head_data    (xif_result.result_data)
  );

  assign xif_result.result_we      = (xif_result.result_rd != 5'd0);
  assign xif_result.result_ecsdata = '0;
  assign xif_result.result_ecswe   = '0;
  assign xif_result.result_exc     = 1'b0;
  assign xif_result.result_exccode = '0;
  assign xif_result.result_err     = 1'b0;
  assign xif_result.result_dbg     = 1'b0;

  assign xif_compressed.compressed_ready = 1'b1;
  assign xif_compressed.compressed_resp  = '0;
  assign xif_mem.mem_valid               = 1'b0;
  assign xif_mem.mem_req                 = '0;

  logic unused;
  assign unused = ^{xif_compressed.compressed_valid, xif_compressed.compressed_instr,
                    xif_mem.mem_ready, xif_mem_result.mem_result_valid,
                    xif_mem_result.mem_result, instr[24:15]};

endmodule

// File: doc/cv32e40s_xif_coproc.md
CV32E40S_XIF_COPROC -- requirements
Module: cv32e40s_xif_coproc

Interface
REQ-001 SHALL have parameter X_ID_WIDTH, default 4: width of the instruction ID.
REQ-002 SHALL have parameter X_NUM_RS, default 2: number of source operands in issue_req.
REQ-003 SHALL have parameter DEPTH, default 4 (power of 2, at least 2): number of in-flight instruction entries.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk, rst.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 xif_compressed  if_xif.coproc_compressed  -  compressed-instruction channel.
REQ-008 xif_issue  if_xif.coproc_issue  -  issue channel.
REQ-009 xif_commit  if_xif.coproc_commit  -  commit/kill channel.
REQ-010 xif_result  if_xif.coproc_result  -  result channel.
REQ-011 xif_mem, xif_mem_result  if_xif.coproc_mem / coproc_mem_result  -  unused; mem_valid=0, mem_req='0.

Function
REQ-012 Compressed channel: compressed_ready=1 and compressed_resp.accept=0 at all times.
REQ-013 Recognized instruction: opcode[6:0]=7'b0001011 and funct7=0, funct3 in {000 ADD, 001 XOR, 010 MIN signed}; everything else is rejected.
REQ-014 issue_ready for a recognized instruction: rs_valid[1:0]==2'b11 AND buffer not full; for a rejected instruction: 1 unconditionally.
REQ-015 issue_resp: accept=recognized; writeback=recognized; dualwrite, dualread, loadstore, ecswrite, exc all 0.
REQ-016 Accepted handshake (issue_valid&issue_ready&accept): allocate tail entry {id, rd=instr[11:7], data=op(rs[0],rs[1]), committed=0, killed=0}, 32-bit wrap arithmetic; result computed in the issue cycle.
REQ-017 Commit (commit_valid): search valid entries for commit.id; commit_kill=1 sets killed, else committed; a non-matching id is ignored with no state change.
REQ-018 Commit in the same cycle as an accepted issue with an equal id SHALL apply to the newly allocated entry.
REQ-019 Buffer is in-order; only the head is presented. result_valid = head valid & committed & !killed, driven from registers only (no combinational path from any input).
REQ-020 Latency: a commit in cycle N makes result_valid=1 in cycle N+1 if that entry is the head.
REQ-021 result fields: id, data, rd from the entry; we=(rd!=0); ecsdata=0, ecswe=0, exc=0, exccode=0, err=0, dbg=0.
REQ-022 result_valid&result_ready pops the head. A killed head pops silently one cycle after it reaches the head. Fields stay stable while result_valid=1 and result_ready=0.
REQ-023 Simultaneous pop and push while full: the push is not permitted (issue_ready=0 per REQ-014); a push and pop when not full both take effect in one cycle.
REQ-024 Pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.

Reset
REQ-025 rst SHALL clear all entry valid/committed/killed flags and the pointers. Outputs during and after reset: issue_ready per REQ-014 with empty buffer, result_valid=0, mem_valid=0, compressed_ready=1.
REQ-026 Reset mid-operation SHALL discard all in-flight entries; no result is emitted for them.

Structure
REQ-027 Opcode/funct3 constants and the entry struct typedef SHALL live in cv32e40s_pkg.
REQ-028 SHALL instantiate one sub-module, cv32e40s_xif_coproc_buf, holding entry storage, pointers, ID search and the commit/kill update; ALU decode stays in the top.

Verification
REQ-029 Issue ADD id=3, rs=5/7, rd=9, commit kill=0 in the next cycle -> result_valid the following cycle with id=3, data=12, rd=9, we=1.
REQ-030 Issue instr=0x00000013 (addi) -> issue_ready=1, accept=0, no entry allocated, no result ever.
REQ-031 Issue 4 accepted ids 0..3 with no commits -> 5th recognized issue sees issue_ready=0; commit id 0 and pop -> issue_ready=1 the next cycle.
REQ-032 Issue ids 1,2; kill id 1, commit id 2; result_ready=1 -> only id 2 is output, exactly once.
REQ-033 MIN with rs=0xFFFFFFFF/1 plus commit in the same cycle as issue -> data=0xFFFFFFFF and result_valid one cycle later; hold result_ready=0 for 3 cycles -> fields stay stable.
REQ-034 Assert rst with 2 committed entries pending -> result_valid=0 immediately; no stale result after rst is released.
